// File: rtl/bus_arb_decoder_pkg.sv
// Shared types and constants for the two-master bus arbiter / address decoder.
// Optional feature macro: BUS_DECERR_EN (decode-error pulse output).
package bus_arb_decoder_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned NUM_SLV = 5;
   localparam int unsigned GNT_W   = 2;

   typedef logic [NUM_SLV-1:0] sel_t;

   // One-hot slave selects: bit4 = slave0 ... bit0 = slave4
   localparam sel_t SEL_NONE = 5'b00000;
   localparam sel_t SEL_S0   = 5'b10000;
   localparam sel_t SEL_S1   = 5'b01000;
   localparam sel_t SEL_S2   = 5'b00100;
   localparam sel_t SEL_S3   = 5'b00010;
   localparam sel_t SEL_S4   = 5'b00001;

   // State encoding doubles as the one-hot grant vector
   typedef enum logic [GNT_W-1:0] {
      ST_IDLE = 2'b00,
      ST_GNT0 = 2'b01,
      ST_GNT1 = 2'b10
   } state_e;

   // Request payload of one master
   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
   } mreq_t;

endpackage

// File: rtl/bus_arb_decoder_if.sv
// Master request / grant / slave-select bundle of the bus front end.
interface bus_arb_decoder_if;
   import bus_arb_decoder_pkg::*;

   logic              m0_req;
   logic [ADDR_W-1:0] m0_addr;
   logic              m1_req;
   logic [ADDR_W-1:0] m1_addr;
   logic [GNT_W-1:0]  m_grant;
   sel_t              s_sel;
   sel_t              rd_sel;
   logic              dec_err;

   // Masters drive requests and observe grant/selects
   modport master (
      output m0_req, m0_addr, m1_req, m1_addr,
      input  m_grant, s_sel, rd_sel, dec_err
   );

   // The arbiter/decoder consumes requests and produces grant/selects
   modport slave (
      input  m0_req, m0_addr, m1_req, m1_addr,
      output m_grant, s_sel, rd_sel, dec_err
   );

endinterface

// File: rtl/bus_arb_decoder_addr_decode.sv
// Combinational base/mask address decoder; lowest-numbered slave wins on overlap.
module addr_decode
   import bus_arb_decoder_pkg::*;
#(
   parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] S0_MASK = 32'hFFFF_F800,
   parameter logic [ADDR_W-1:0] S1_BASE = 32'h0000_7000,
   parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S2_BASE = 32'h0000_7100,
   parameter logic [ADDR_W-1:0] S2_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S3_BASE = 32'h0000_7200,
   parameter logic [ADDR_W-1:0] S3_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S4_BASE = 32'h0000_7300,
   parameter logic [ADDR_W-1:0] S4_MASK = 32'hFFFF_FF00
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              en,
   output sel_t              sel
);

   // Priority match keeps the result one-hot or zero
   always_comb begin
      sel = SEL_NONE;
      if (en) begin
         if      ((addr & S0_MASK) == S0_BASE) sel = SEL_S0;
         else if ((addr & S1_MASK) == S1_BASE) sel = SEL_S1;
         else if ((addr & S2_MASK) == S2_BASE) sel = SEL_S2;
         else if ((addr & S3_MASK) == S3_BASE) sel = SEL_S3;
         else if ((addr & S4_MASK) == S4_BASE) sel = SEL_S4;
      end
   end

endmodule

// File: rtl/dff_r.sv
// Generic W-bit register with asynchronous active-low reset to zero.
module dff_r #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;

   // Capture d every edge; clear on reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) q_q <= '0;
      else          q_q <= d;
   end

   assign q = q_q;

endmodule

// File: rtl/bus_arb_decoder.sv
// Two-master fixed-priority arbiter (no preemption) with one-hot slave decode.
// s_sel is the address-phase select; rd_sel is its registered data-phase copy.
// Optional feature macro: BUS_DECERR_EN adds a registered decode-error pulse.
module bus_arb_decoder
   import bus_arb_decoder_pkg::*;
#(
   parameter logic [ADDR_W-1:0] S0_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] S0_MASK = 32'hFFFF_F800,
   parameter logic [ADDR_W-1:0] S1_BASE = 32'h0000_7000,
   parameter logic [ADDR_W-1:0] S1_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S2_BASE = 32'h0000_7100,
   parameter logic [ADDR_W-1:0] S2_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S3_BASE = 32'h0000_7200,
   parameter logic [ADDR_W-1:0] S3_MASK = 32'hFFFF_FF00,
   parameter logic [ADDR_W-1:0] S4_BASE = 32'h0000_7300,
   parameter logic [ADDR_W-1:0] S4_MASK = 32'hFFFF_FF00
) (
   input  logic              clk,
   input  logic              reset_n,
   bus_arb_decoder_if.slave  bus
);

   state_e state_q, state_d;
   mreq_t  gnt_req;
   sel_t   s_sel_c;
   sel_t   rd_sel_q;

   // Arbitration state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Next state: m0 priority from idle, tenure held until release, direct handoff
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if      (bus.m0_req) state_d = ST_GNT0;
            else if (bus.m1_req) state_d = ST_GNT1;
         end
         ST_GNT0: begin
            if (!bus.m0_req) state_d = bus.m1_req ? ST_GNT1 : ST_IDLE;
         end
         ST_GNT1: begin
            if (!bus.m1_req) state_d = bus.m0_req ? ST_GNT0 : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Select the granted master's request; an ungranted bus decodes nothing
   always_comb begin
      gnt_req = '0;
      unique case (state_q)
         ST_GNT0: gnt_req = '{req: bus.m0_req, addr: bus.m0_addr};
         ST_GNT1: gnt_req = '{req: bus.m1_req, addr: bus.m1_addr};
         default: gnt_req = '0;
      endcase
   end

   addr_decode #(
      .S0_BASE (S0_BASE), .S0_MASK (S0_MASK),
      .S1_BASE (S1_BASE), .S1_MASK (S1_MASK),
      .S2_BASE (S2_BASE), .S2_MASK (S2_MASK),
      .S3_BASE (S3_BASE), .S3_MASK (S3_MASK),
      .S4_BASE (S4_BASE), .S4_MASK (S4_MASK)
   ) u_addr_decode (
      .addr (gnt_req.addr),
      .en   (gnt_req.req),
      .sel  (s_sel_c)
   );

   dff_r #(.W(NUM_SLV)) u_rd_sel (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (s_sel_c),
      .q       (rd_sel_q)
   );

`ifdef BUS_DECERR_EN
   logic dec_err_q, dec_err_d;

   // Flag an active granted request that hit no slave
   always_comb begin
      dec_err_d = gnt_req.req && (s_sel_c == SEL_NONE);
   end

   // One-cycle decode-error pulse register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dec_err_q <= 1'b0;
      else          dec_err_q <= dec_err_d;
   end

   assign bus.dec_err = dec_err_q;
`else
   assign bus.dec_err = 1'b0;
`endif

   assign bus.m_grant = GNT_W'(state_q);
   assign bus.s_sel   = s_sel_c;
   assign bus.rd_sel  = rd_sel_q;

endmodule

// File: tb/tb_bus_arb_decoder.sv
// Self-checking bench for bus_arb_decoder: directed vector table, corner sequences,
// and randomized traffic against a behavioural ownership/decode model.
module tb_bus_arb_decoder;

`ifdef BUS_DECERR_EN
   localparam bit DECERR_ON = 1'b1;
`else
   localparam bit DECERR_ON = 1'b0;
`endif

   logic clk;
   logic reset_n;
   int   n_checks;
   int   n_errors;

   bus_arb_decoder_if bus ();
   bus_arb_decoder_if bus_ov ();

   bus_arb_decoder u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   bus_arb_decoder #(
      .S1_BASE (32'h0000_0000),
      .S1_MASK (32'hFFFF_F800)
   ) u_dut_ov (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_ov.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [31:0] ref_base [5];
   logic [31:0] ref_mask [5];
   int          owner;     // 0 = nobody, 1 = master0, 2 = master1
   logic [4:0]  exp_rd;
   bit          exp_dec;

   function automatic logic [4:0] ref_decode(input logic [31:0] a);
      for (int k = 0; k < 5; k++) begin
         if ((a & ref_mask[k]) == ref_base[k]) return 5'(1 << (4 - k));
      end
      return 5'b00000;
   endfunction

   function automatic logic [4:0] ref_ssel();
      if (owner == 1 && bus.m0_req) return ref_decode(bus.m0_addr);
      if (owner == 2 && bus.m1_req) return ref_decode(bus.m1_addr);
      return 5'b00000;
   endfunction

   function automatic logic [1:0] ref_grant();
      if (owner == 1) return 2'b01;
      if (owner == 2) return 2'b10;
      return 2'b00;
   endfunction

   task automatic ref_reset();
      owner   = 0;
      exp_rd  = 5'b00000;
      exp_dec = 1'b0;
   endtask

   // Advance the model across one rising edge using the current inputs
   task automatic ref_edge();
      logic [4:0] s;
      bit         owner_req;
      s         = ref_ssel();
      owner_req = (owner == 1 && bus.m0_req) || (owner == 2 && bus.m1_req);
      exp_dec   = DECERR_ON && owner_req && (s == 5'b00000);
      exp_rd    = s;
      case (owner)
         0: owner = bus.m0_req ? 1 : (bus.m1_req ? 2 : 0);
         1: if (!bus.m0_req) owner = bus.m1_req ? 2 : 0;
         2: if (!bus.m1_req) owner = bus.m0_req ? 1 : 0;
         default: owner = 0;
      endcase
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1);
      bus.m0_req  = r0;
      bus.m0_addr = a0;
      bus.m1_req  = r1;
      bus.m1_addr = a1;
   endtask

   // One model-checked cycle, entered and left at a falling edge
   task automatic cyc(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1);
      drive(r0, a0, r1, a1);
      #1;
      chk("s_sel", 32'(bus.s_sel), 32'(ref_ssel()));
      ref_edge();
      @(posedge clk);
      #1;
      chk("m_grant", 32'(bus.m_grant), 32'(ref_grant()));
      chk("rd_sel", 32'(bus.rd_sel), 32'(exp_rd));
      chk("dec_err", 32'(bus.dec_err), 32'(exp_dec));
      chk("grant_not_11", 32'(bus.m_grant == 2'b11), 32'd0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      case ($urandom_range(0, 5))
         0:       a = $urandom;
         1:       a = 32'($urandom_range(0, 32'h7FF));
         2:       a = 32'h0000_7000 + 32'($urandom_range(0, 3) * 256) + 32'($urandom_range(0, 255));
         3:       a = 32'h0000_7400 + 32'($urandom_range(0, 32'hBFF));
         4:       a = 32'h0000_0800 + 32'($urandom_range(0, 32'h67FF));
         default: a = 32'h0000_7000 + 32'($urandom_range(0, 255));
      endcase
      return a;
   endfunction

   // ---------------- directed vector table ----------------
   typedef struct {
      bit          m0r;
      logic [31:0] a0;
      bit          m1r;
      logic [31:0] a1;
      logic [4:0]  pre_ssel;   // s_sel with these inputs, before the edge
      logic [1:0]  grant;      // after the edge
      logic [4:0]  rd;         // after the edge
      bit          dec;        // after the edge, when the error pulse is built in
   } vec_t;

   vec_t tbl [12];

   initial begin
      n_checks = 0;
      n_errors = 0;
      ref_base = '{32'h0000_0000, 32'h0000_7000, 32'h0000_7100, 32'h0000_7200, 32'h0000_7300};
      ref_mask = '{32'hFFFF_F800, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00};

      tbl[0]  = '{1'b1, 32'h10,   1'b1, 32'h7204, 5'b00000, 2'b01, 5'b00000, 1'b0};
      tbl[1]  = '{1'b1, 32'h10,   1'b1, 32'h7204, 5'b10000, 2'b01, 5'b10000, 1'b0};
      tbl[2]  = '{1'b0, 32'h10,   1'b1, 32'h7204, 5'b00000, 2'b10, 5'b00000, 1'b0};
      tbl[3]  = '{1'b0, 32'h10,   1'b1, 32'h7204, 5'b00010, 2'b10, 5'b00010, 1'b0};
      tbl[4]  = '{1'b1, 32'h10,   1'b1, 32'h7104, 5'b00100, 2'b10, 5'b00100, 1'b0};
      tbl[5]  = '{1'b1, 32'h10,   1'b1, 32'h7104, 5'b00100, 2'b10, 5'b00100, 1'b0};
      tbl[6]  = '{1'b1, 32'h10,   1'b0, 32'h7104, 5'b00000, 2'b01, 5'b00000, 1'b0};
      tbl[7]  = '{1'b1, 32'h9000, 1'b0, 32'h0,    5'b00000, 2'b01, 5'b00000, 1'b1};
      tbl[8]  = '{1'b1, 32'h7000, 1'b0, 32'h0,    5'b01000, 2'b01, 5'b01000, 1'b0};
      tbl[9]  = '{1'b0, 32'h7000, 1'b0, 32'h0,    5'b00000, 2'b00, 5'b00000, 1'b0};
      tbl[10] = '{1'b0, 32'h0,    1'b1, 32'h7300, 5'b00000, 2'b10, 5'b00000, 1'b0};
      tbl[11] = '{1'b0, 32'h0,    1'b1, 32'h7300, 5'b00001, 2'b10, 5'b00001, 1'b0};

      // Reset state
      reset_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      bus_ov.m0_req  = 1'b0;
      bus_ov.m0_addr = 32'h0;
      bus_ov.m1_req  = 1'b0;
      bus_ov.m1_addr = 32'h0;
      ref_reset();
      repeat (2) @(negedge clk);
      chk("rst_grant", 32'(bus.m_grant), 32'd0);
      chk("rst_rd_sel", 32'(bus.rd_sel), 32'd0);
      chk("rst_dec_err", 32'(bus.dec_err), 32'd0);
      chk("rst_s_sel", 32'(bus.s_sel), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Directed table
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].m0r, tbl[i].a0, tbl[i].m1r, tbl[i].a1);
         #1;
         chk($sformatf("tbl%0d_s_sel", i), 32'(bus.s_sel), 32'(tbl[i].pre_ssel));
         ref_edge();
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_grant", i), 32'(bus.m_grant), 32'(tbl[i].grant));
         chk($sformatf("tbl%0d_rd_sel", i), 32'(bus.rd_sel), 32'(tbl[i].rd));
         chk($sformatf("tbl%0d_dec_err", i), 32'(bus.dec_err), 32'(tbl[i].dec & DECERR_ON));
         @(negedge clk);
      end

      // Async reset in the middle of a master0 tenure
      cyc(1'b1, 32'h10, 1'b0, 32'h0);
      cyc(1'b1, 32'h10, 1'b0, 32'h0);
      cyc(1'b1, 32'h10, 1'b0, 32'h0);
      chk("pre_rst_s_sel", 32'(bus.s_sel), 32'(5'b10000));
      chk("pre_rst_rd_sel", 32'(bus.rd_sel), 32'(5'b10000));
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst_grant", 32'(bus.m_grant), 32'd0);
      chk("async_rst_rd_sel", 32'(bus.rd_sel), 32'd0);
      chk("async_rst_s_sel", 32'(bus.s_sel), 32'd0);
      ref_reset();
      drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // Overlapping slave1 window: slave0 must still win
      bus_ov.m0_req  = 1'b1;
      bus_ov.m0_addr = 32'h10;
      @(posedge clk);
      #1;
      chk("ov_grant", 32'(bus_ov.m_grant), 32'(2'b01));
      chk("ov_s_sel", 32'(bus_ov.s_sel), 32'(5'b10000));
      bus_ov.m0_addr = 32'h7304;
      #1;
      chk("ov_s_sel_s4", 32'(bus_ov.s_sel), 32'(5'b00001));
      @(negedge clk);
      bus_ov.m0_req = 1'b0;

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         bit r0, r1;
         r0 = ($urandom_range(0, 3) != 0);
         r1 = ($urandom_range(0, 3) != 0);
         cyc(r0, rand_addr(), r1, rand_addr());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
